// File: rtl/cpu_defs.sv
// Shared definitions for the RV32I out-of-order core: widths, register
// index constants and the common word/index types.
package cpu_defs;

    localparam int ROB_WIDTH     = 4;
    localparam int REG_IDX_WIDTH = 5;
    localparam int XLEN          = 32;
    localparam int NUM_REGS      = 2 ** REG_IDX_WIDTH;

    localparam logic [REG_IDX_WIDTH-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_IDX_WIDTH-1:0] regIdxT;
    typedef logic [XLEN-1:0]          wordT;

endpackage

// File: rtl/register_file_if.sv
// Bus between the instruction unit / reorder buffer and the register file:
// stall and flush, commit write, rename at dispatch and two operand lookups.
interface register_file_if #(
    parameter int ROB_WIDTH = cpu_defs::ROB_WIDTH
);
    import cpu_defs::*;

    logic                 readyIn;
    logic                 clear;

    logic                 regUpdateValid;
    regIdxT               regUpdateDest;
    wordT                 regValue;
    logic [ROB_WIDTH-1:0] regUpdateRobId;

    logic                 renameValid;
    regIdxT               renameDest;
    logic [ROB_WIDTH-1:0] renameRobId;

    regIdxT               rs1;
    logic                 rs1Dirty;
    logic [ROB_WIDTH-1:0] rs1Dep;
    wordT                 rs1Value;

    regIdxT               rs2;
    logic                 rs2Dirty;
    logic [ROB_WIDTH-1:0] rs2Dep;
    wordT                 rs2Value;

    modport master (
        output readyIn, clear,
        output regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output renameValid, renameDest, renameRobId,
        output rs1, rs2,
        input  rs1Dirty, rs1Dep, rs1Value,
        input  rs2Dirty, rs2Dep, rs2Value
    );

    modport slave (
        input  readyIn, clear,
        input  regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  renameValid, renameDest, renameRobId,
        input  rs1, rs2,
        output rs1Dirty, rs1Dep, rs1Value,
        output rs2Dirty, rs2Dep, rs2Value
    );

endinterface

// File: rtl/reg_read_port.sv
// One combinational source-operand lookup: commit bypass, pending-tag report
// or the architectural value, in that priority order.
module reg_read_port
    import cpu_defs::*;
#(
    parameter int TAG_WIDTH = cpu_defs::ROB_WIDTH
) (
    input  regIdxT                             rsIdx,
    input  logic [NUM_REGS-1:0]                busyVec,
    input  logic [NUM_REGS-1:0][TAG_WIDTH-1:0] tagVec,
    input  logic [NUM_REGS-1:0][XLEN-1:0]      regVec,
    input  logic                               commitValid,
    input  regIdxT                             commitDest,
    input  wordT                               commitValue,
    input  logic [TAG_WIDTH-1:0]               commitRobId,
    output logic                               dirty,
    output logic [TAG_WIDTH-1:0]               dep,
    output wordT                               value
);

    logic bypassHit;

    // The committing entry is exactly the producer this source waits on.
    always_comb begin
        bypassHit = busyVec[rsIdx] && commitValid &&
                    (commitDest == rsIdx) && (commitRobId == tagVec[rsIdx]);
    end

    always_comb begin
        dirty = 1'b0;
        dep   = '0;
        value = '0;
        if (rsIdx != REG_ZERO) begin
            if (bypassHit) begin
                value = commitValue;
            end else if (busyVec[rsIdx]) begin
                dirty = 1'b1;
                dep   = tagVec[rsIdx];
            end else begin
                value = regVec[rsIdx];
            end
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with rename tags: commits from the reorder
// buffer, dispatch renames, misprediction clear and two operand lookups.
module register_file #(
    parameter int ROB_WIDTH = cpu_defs::ROB_WIDTH
) (
    input  logic            clockIn,
    input  logic            resetIn,
    register_file_if.slave  bus
);
    import cpu_defs::*;

    logic [NUM_REGS-1:0]                busy;
    logic [NUM_REGS-1:0][ROB_WIDTH-1:0] tags;
    logic [NUM_REGS-1:0][XLEN-1:0]      regs;

    logic commitEn;
    logic renameEn;

    always_comb begin
        commitEn = bus.readyIn && bus.regUpdateValid && (bus.regUpdateDest != REG_ZERO);
        renameEn = bus.readyIn && bus.renameValid && !bus.clear &&
                   (bus.renameDest != REG_ZERO);
    end

    // Later assignments win: a clear overrides the commit's busy release,
    // and a rename overrides both on busy and tag.
    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            regs <= '0;
            busy <= '0;
            tags <= '0;
        end else begin
            if (commitEn) begin
                regs[bus.regUpdateDest] <= bus.regValue;
                if (tags[bus.regUpdateDest] == bus.regUpdateRobId) begin
                    busy[bus.regUpdateDest] <= 1'b0;
                end
            end
            if (bus.readyIn && bus.clear) begin
                busy <= '0;
            end
            if (renameEn) begin
                busy[bus.renameDest] <= 1'b1;
                tags[bus.renameDest] <= bus.renameRobId;
            end
        end
    end

    reg_read_port #(
        .TAG_WIDTH (ROB_WIDTH)
    ) readPort1 (
        .rsIdx       (bus.rs1),
        .busyVec     (busy),
        .tagVec      (tags),
        .regVec      (regs),
        .commitValid (bus.regUpdateValid),
        .commitDest  (bus.regUpdateDest),
        .commitValue (bus.regValue),
        .commitRobId (bus.regUpdateRobId),
        .dirty       (bus.rs1Dirty),
        .dep         (bus.rs1Dep),
        .value       (bus.rs1Value)
    );

    reg_read_port #(
        .TAG_WIDTH (ROB_WIDTH)
    ) readPort2 (
        .rsIdx       (bus.rs2),
        .busyVec     (busy),
        .tagVec      (tags),
        .regVec      (regs),
        .commitValid (bus.regUpdateValid),
        .commitDest  (bus.regUpdateDest),
        .commitValue (bus.regValue),
        .commitRobId (bus.regUpdateRobId),
        .dirty       (bus.rs2Dirty),
        .dep         (bus.rs2Dep),
        .value       (bus.rs2Value)
    );

endmodule
